// File: rtl/matrix_addsub_engine.sv
// Element-wise N x N matrix add/subtract engine, LANES elements per cycle, busy/done handshake.
// Optional clamping of results to the OW range when MATRIX_ADDSUB_SAT_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; op and mode are captured on accept
// ST_RUN  | writing LANES result elements per cycle in row-major order
// ST_DONE | one-cycle completion pulse, busy still high

module matrix_addsub_engine #(
   parameter int N     = 4,
   parameter int DW    = 8,
   parameter int OW    = 16,
   parameter int LANES = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   input  logic [1:0]    i_op,
   input  logic          i_signed_mode,
   input  logic [DW-1:0] i_a [0:N-1][0:N-1],
   input  logic [DW-1:0] i_b [0:N-1][0:N-1],
   output logic [OW-1:0] o_c [0:N-1][0:N-1],
   output logic          o_busy,
   output logic          o_done,
   output logic          o_sat_flag
);

   localparam int NE = N * N;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;
   localparam int RW = (N > 1) ? $clog2(N) : 1;
   localparam int XW = OW + 2;

   if (N < 1) begin : g_bad_n
      $error("matrix_addsub_engine: N must be at least 1");
   end
   if (OW < DW) begin : g_bad_ow
      $error("matrix_addsub_engine: OW must be at least DW");
   end
   if ((LANES < 1) || ((NE % LANES) != 0)) begin : g_bad_lanes
      $error("matrix_addsub_engine: LANES must divide N*N");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t        r_state;
   logic [IW-1:0] r_idx;
   logic [1:0]    r_op;
   logic          r_sm;
   logic          r_busy;
   logic          r_done;
   logic          r_sat;
   logic [OW-1:0] r_c [0:N-1][0:N-1];

   logic [OW:0]   w_lane [LANES];
   logic [RW-1:0] w_row  [LANES];
   logic [RW-1:0] w_col  [LANES];
   logic          w_any_sat;

   // One extra bit of headroom beyond OW+1 keeps the unsigned OW==DW sum unambiguous
   // when clamping; the low OW+1 bits are the same as a plain OW+1-bit computation.
   function automatic logic [OW:0] f_elem(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [1:0]    op,
                                          input logic          sm);
      logic signed [XW-1:0] ea;
      logic signed [XW-1:0] eb;
      logic signed [XW-1:0] v;
      logic [OW-1:0]        res;
      logic                 sat;
      ea = sm ? {{(XW-DW){a[DW-1]}}, a} : {{(XW-DW){1'b0}}, a};
      eb = sm ? {{(XW-DW){b[DW-1]}}, b} : {{(XW-DW){1'b0}}, b};
      case (op)
         2'b00:   v = ea + eb;
         2'b01:   v = ea - eb;
         2'b10:   v = eb - ea;
         default: v = (ea < eb) ? (eb - ea) : (ea - eb);
      endcase
      res = v[OW-1:0];
      sat = 1'b0;
`ifdef MATRIX_ADDSUB_SAT_EN
      if (sm) begin
         if (!v[XW-1] && (v[XW-2:OW-1] != '0)) begin
            res = {1'b0, {(OW-1){1'b1}}};
            sat = 1'b1;
         end else if (v[XW-1] && (v[XW-2:OW-1] != '1)) begin
            res = {1'b1, {(OW-1){1'b0}}};
            sat = 1'b1;
         end
      end else begin
         if (v[XW-1]) begin
            res = '0;
            sat = 1'b1;
         end else if (v[XW-2:OW] != '0) begin
            res = '1;
            sat = 1'b1;
         end
      end
`endif
      return {sat, res};
   endfunction

   always_comb begin
      w_any_sat = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         w_row[l]  = RW'((int'(r_idx) + l) / N);
         w_col[l]  = RW'((int'(r_idx) + l) % N);
         w_lane[l] = f_elem(i_a[w_row[l]][w_col[l]], i_b[w_row[l]][w_col[l]], r_op, r_sm);
         w_any_sat = w_any_sat | w_lane[l][OW];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_op    <= '0;
         r_sm    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sat   <= 1'b0;
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               r_c[r][c] <= '0;
            end
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_RUN;
                  r_op    <= i_op;
                  r_sm    <= i_signed_mode;
                  r_idx   <= '0;
                  r_sat   <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               for (int l = 0; l < LANES; l++) begin
                  r_c[w_row[l]][w_col[l]] <= w_lane[l][OW-1:0];
               end
               r_sat <= r_sat | w_any_sat;
               if (r_idx == IW'(NE - LANES)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= r_idx + IW'(LANES);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_c        = r_c;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_sat_flag = r_sat;

endmodule

// File: tb/tb_matrix_addsub_engine.sv
// Bench for matrix_addsub_engine: two instances (LANES=1/OW=16 and LANES=4/OW=8) against an
// integer-arithmetic reference model; follows MATRIX_ADDSUB_SAT_EN when defined.

module tb_matrix_addsub_engine;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int NE  = N * N;
   localparam int OW1 = 16;
   localparam int OW2 = 8;
   localparam int L1  = 1;
   localparam int L2  = 4;
`ifdef MATRIX_ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start1 = 1'b0, start2 = 1'b0;
   logic [1:0]     op1 = '0, op2 = '0;
   logic           sm1 = 1'b0, sm2 = 1'b0;
   logic [DW-1:0]  a1 [0:N-1][0:N-1];
   logic [DW-1:0]  b1 [0:N-1][0:N-1];
   logic [DW-1:0]  a2 [0:N-1][0:N-1];
   logic [DW-1:0]  b2 [0:N-1][0:N-1];
   logic [OW1-1:0] c1 [0:N-1][0:N-1];
   logic [OW2-1:0] c2 [0:N-1][0:N-1];
   logic           busy1, done1, sat1, busy2, done2, sat2;

   int total = 0;
   int bad   = 0;
   int prev_c [2][NE];

   always #5 clk = ~clk;

   matrix_addsub_engine #(.N(N), .DW(DW), .OW(OW1), .LANES(L1)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start(start1), .i_op(op1), .i_signed_mode(sm1),
      .i_a(a1), .i_b(b1), .o_c(c1), .o_busy(busy1), .o_done(done1), .o_sat_flag(sat1)
   );

   matrix_addsub_engine #(.N(N), .DW(DW), .OW(OW2), .LANES(L2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(start2), .i_op(op2), .i_signed_mode(sm2),
      .i_a(a2), .i_b(b2), .o_c(c2), .o_busy(busy2), .o_done(done2), .o_sat_flag(sat2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] get_c(input int sel, input int k);
      if (sel == 0) return 64'(c1[k / N][k % N]);
      return 64'(c2[k / N][k % N]);
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? busy1 : busy2;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 0) ? done1 : done2;
   endfunction

   function automatic logic get_sat(input int sel);
      return (sel == 0) ? sat1 : sat2;
   endfunction

   function automatic int get_a(input int sel, input int k);
      return (sel == 0) ? int'(a1[k / N][k % N]) : int'(a2[k / N][k % N]);
   endfunction

   function automatic int get_b(input int sel, input int k);
      return (sel == 0) ? int'(b1[k / N][k % N]) : int'(b2[k / N][k % N]);
   endfunction

   task automatic set_ab(input int sel, input int k, input int av, input int bv);
      if (sel == 0) begin
         a1[k / N][k % N] = DW'(av);
         b1[k / N][k % N] = DW'(bv);
      end else begin
         a2[k / N][k % N] = DW'(av);
         b2[k / N][k % N] = DW'(bv);
      end
   endtask

   task automatic fill_const(input int sel, input int av, input int bv);
      for (int k = 0; k < NE; k++) set_ab(sel, k, av, bv);
   endtask

   task automatic fill_rand(input int sel);
      for (int k = 0; k < NE; k++) set_ab(sel, k, int'($urandom_range(255)), int'($urandom_range(255)));
   endtask

   task automatic drive(input int sel, input logic s, input int opv, input logic smv);
      if (sel == 0) begin
         start1 = s; op1 = 2'(opv); sm1 = smv;
      end else begin
         start2 = s; op2 = 2'(opv); sm2 = smv;
      end
   endtask

   // Reference: operands as mathematical integers, then clamp or wrap to ow bits.
   task automatic model_elem(input int av, input int bv, input int opv, input bit smv,
                             input int ow, output int res, output bit s);
      int x, y, v, lo, hi;
      x = (smv && av >= (1 << (DW - 1))) ? av - (1 << DW) : av;
      y = (smv && bv >= (1 << (DW - 1))) ? bv - (1 << DW) : bv;
      case (opv)
         0:       v = x + y;
         1:       v = x - y;
         2:       v = y - x;
         default: v = (x > y) ? x - y : y - x;
      endcase
      s = 1'b0;
      if (SAT) begin
         lo = smv ? -(1 << (ow - 1)) : 0;
         hi = smv ? (1 << (ow - 1)) - 1 : (1 << ow) - 1;
         if (v < lo) begin v = lo; s = 1'b1; end
         else if (v > hi) begin v = hi; s = 1'b1; end
      end
      res = v & ((1 << ow) - 1);
   endtask

   task automatic run_op(input int sel, input int opv, input bit smv,
                         input bit hold, input bit poke, input string tag);
      int  nc [NE];
      bit  ns, s;
      int  lanes, kc, ow, nbad, expv, t;
      lanes = (sel == 0) ? L1 : L2;
      ow    = (sel == 0) ? OW1 : OW2;
      kc    = NE / lanes;
      ns    = 1'b0;
      for (int k = 0; k < NE; k++) begin
         model_elem(get_a(sel, k), get_b(sel, k), opv, smv, ow, nc[k], s);
         ns = ns | s;
      end
      drive(sel, 1'b1, opv, smv);
      @(posedge clk); #1;
      if (!hold) drive(sel, 1'b0, opv, smv);
      for (int j = 1; j <= kc + 2; j++) begin
         if (poke && j == 3) drive(sel, 1'b1, 0, smv);
         if (poke && j == 4) drive(sel, 1'b0, opv, smv);
         @(negedge clk);
         chk({tag, "_done"}, 64'(get_done(sel)), 64'(j == kc + 1));
         chk({tag, "_busy"}, 64'(get_busy(sel)), 64'(j <= kc + 1));
         nbad = 0;
         for (int k = 0; k < NE; k++) begin
            expv = (j >= 2 + k / lanes) ? nc[k] : prev_c[sel][k];
            if (get_c(sel, k) !== 64'(expv)) nbad++;
         end
         chk({tag, "_c_bad_elems"}, 64'(nbad), 64'd0);
         if (j == kc + 1) chk({tag, "_sat"}, 64'(get_sat(sel)), 64'(ns));
         @(posedge clk); #1;
      end
      for (int k = 0; k < NE; k++) prev_c[sel][k] = nc[k];
      if (hold) begin
         @(negedge clk);
         chk({tag, "_rearm_busy"}, 64'(get_busy(sel)), 64'd1);
         drive(sel, 1'b0, opv, smv);
         t = 0;
         while (t < 64 && !get_done(sel)) begin
            @(negedge clk);
            t++;
         end
         chk({tag, "_rearm_done"}, 64'(get_done(sel)), 64'd1);
         @(posedge clk); #1;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      int nbad;
      nbad = 0;
      for (int sel = 0; sel < 2; sel++) begin
         for (int k = 0; k < NE; k++) if (get_c(sel, k) !== 64'd0) nbad++;
      end
      chk({tag, "_c_nonzero"}, 64'(nbad), 64'd0);
      chk({tag, "_busy1"}, 64'(busy1), 64'd0);
      chk({tag, "_done1"}, 64'(done1), 64'd0);
      chk({tag, "_sat1"},  64'(sat1),  64'd0);
      chk({tag, "_busy2"}, 64'(busy2), 64'd0);
      chk({tag, "_sat2"},  64'(sat2),  64'd0);
      for (int sel = 0; sel < 2; sel++) begin
         for (int k = 0; k < NE; k++) prev_c[sel][k] = 0;
      end
   endtask

   initial begin
      int ndone, opv;
      bit smv;
      fill_const(0, 0, 0);
      fill_const(1, 0, 0);

      // Reset with start asserted: must be ignored
      rst = 1'b1;
      drive(0, 1'b1, 1, 1'b0);
      drive(1, 1'b1, 1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 1'b0, 0, 1'b0);
      drive(1, 1'b0, 0, 1'b0);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;

      fill_const(0, 5, 3);
      run_op(0, 1, 1'b0, 1'b0, 1'b0, "usub_5_3");
      chk("usub_5_3_c00", get_c(0, 0), 64'd2);

      fill_const(0, -128, -128);
      run_op(0, 0, 1'b1, 1'b0, 1'b0, "sadd_m128");
      chk("sadd_m128_c15", get_c(0, 15), 64'hFF00);

      fill_const(0, 3, 5);
      run_op(0, 1, 1'b0, 1'b0, 1'b0, "usub_3_5");
      chk("usub_3_5_c07", get_c(0, 7), SAT ? 64'd0 : 64'hFFFE);

      fill_const(0, -3, 4);
      run_op(0, 3, 1'b1, 1'b0, 1'b1, "sabs_poke");
      chk("sabs_c09", get_c(0, 9), 64'd7);

      // Reset after five elements of a new operation have been written
      fill_const(0, 20, 1);
      drive(0, 1'b1, 0, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_c4_written", get_c(0, 4), 64'd21);
      chk("midrst_c5_old", get_c(0, 5), 64'd7);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done1 !== 1'b0 || busy1 !== 1'b0) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);
      @(posedge clk); #1;

      for (int k = 0; k < NE; k++) set_ab(1, k, k, 1);
      run_op(1, 0, 1'b0, 1'b0, 1'b0, "l4_ramp");
      chk("l4_ramp_c23", get_c(1, 2 * N + 3), 64'd12);

      fill_const(1, 100, 100);
      run_op(1, 0, 1'b1, 1'b0, 1'b0, "ow8_sadd");
      chk("ow8_sadd_c0", get_c(1, 0), SAT ? 64'h7F : 64'hC8);

      fill_const(1, 3, 5);
      run_op(1, 1, 1'b0, 1'b0, 1'b0, "ow8_usub");

      for (int it = 0; it < 8; it++) begin
         fill_rand(it % 2);
         opv = int'($urandom_range(3));
         smv = 1'(int'($urandom_range(1)));
         run_op(it % 2, opv, smv, (it == 2 || it == 5), 1'b0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_addsub_engine.md
# matrix_addsub_engine

Parametrised element-wise matrix add/subtract engine for the NPU datapath. It supersedes the fixed 4x4 unsigned subtractor. It adds:
- configurable matrix size, operand/result widths and lanes per cycle;
- a runtime operation select and signed/unsigned mode;
- a busy/done handshake and optional saturation.

It sits beside the other matrix units behind the same start/done control, reading two operand matrices and writing a result matrix register.

## Interface
- N, 4, matrix dimension (N x N elements), N >= 1
- DW, 8, operand element width
- OW, 16, result element width, OW >= DW
- LANES, 1, elements processed per cycle; must divide N*N (elaboration error otherwise)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- start  in  1  request; accepted only in IDLE
- op  in  2  00 a+b, 01 a-b, 10 b-a, 11 |a-b|; captured at accept
- signed_mode  in  1  1 = operands two's complement; captured at accept
- a  in  DW x [0:N-1][0:N-1]  operand A; must be held stable while busy
- b  in  DW x [0:N-1][0:N-1]  operand B; same rule
- c  out  OW x [0:N-1][0:N-1]  result register
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- sat_flag  out  1  sticky per operation: some element saturated

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1.
  - Latch op and signed_mode.
  - Clear idx to 0 and sat_flag to 0.
- RUN: each cycle compute LANES elements at flat indices idx..idx+LANES-1.
  - Order is row-major: row = k / N, col = k % N.
  - Write them into c; idx += LANES.
  - After the write at idx = N*N-LANES, go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- start while busy: ignored, with no effect on the latched op or mode.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- c elements keep their value until rewritten; every element is rewritten by every operation.
- Arithmetic:
  - Extend each operand to OW+1 bits: sign-extend if signed_mode, else zero-extend.
  - Compute the op result in OW+1 bits.
  - |a-b| is the magnitude of the OW+1-bit difference.
  - Reduce to OW bits per Configuration.
- Reset (any cycle, including mid-RUN): state IDLE, idx 0, every c element 0, busy 0, done 0, sat_flag 0. A partially written result is discarded; no done is issued.

## Timing
- start sampled high in IDLE at edge T: RUN during cycles T+1 .. T+K, where K = N*N/LANES.
- done high in cycle T+K+1 only; busy low again from T+K+2.
- Back-to-back: earliest next accept is at edge T+K+2, i.e. a period of K+2 cycles.
- c[row][col] for flat index k is visible from cycle T+2+floor(k/LANES).
- sat_flag is valid when done=1 and holds until the next accept or reset.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- MATRIX_ADDSUB_SAT_EN defined: the OW+1-bit result is clamped to the OW range.
  - Signed mode range: [-2^(OW-1), 2^(OW-1)-1].
  - Unsigned mode range: [0, 2^OW-1].
  - Any clamp sets sat_flag.
- MATRIX_ADDSUB_SAT_EN undefined: the result is truncated to its low OW bits (wrap-around). sat_flag is tied to 0.

## Test plan
- Reset: rst high for 2 cycles, with N=4 defaults -> all c = 0, busy = 0, done = 0, sat_flag = 0; start asserted during rst is ignored.
- Unsigned a-b, a = all 5, b = all 3, LANES=1, start at edge T:
  - every c = 16'h0002;
  - done high only in cycle T+17;
  - busy low at T+18.
- Signed a+b, a = all -128, b = all -128 -> every c = 16'hFF00 (-256), sat_flag = 0.
- Unsigned a-b, a = 3, b = 5:
  - without macro -> c = 16'hFFFE;
  - with MATRIX_ADDSUB_SAT_EN -> c = 0 and sat_flag = 1.
  - With OW=8, signed a+b of 100+100 -> 8'hC8 wrap, or 8'h7F with the macro.
- |a-b|, signed, a = -3, b = 4 -> c = 7.
  - A start pulse during RUN, with op changed to 00, has no effect.
  - rst asserted after 5 elements are written -> all c = 0, IDLE, no done pulse.
- LANES=4, N=4, a = row-major 0..15, b = all 1, op a+b:
  - c[r][col] = 4r+col+1;
  - done in cycle T+5;
  - 4 elements update per cycle in row-major order.
